// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice.
//   SHOP_*    : operation encodings on req_op (2'b11 is reserved and runs as SLL)
//   SH_W      : datapath width
//   bit_rev32 : 32-bit bit reversal, used to build right shifts from a left shifter
package shift_pkg;

  localparam int SH_W = 32;

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  function automatic logic [SH_W-1:0] bit_rev32(input logic [SH_W-1:0] x);
    logic [SH_W-1:0] r;
    for (int i = 0; i < SH_W; i++) begin
      r[i] = x[SH_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bus between the requesters and the shared shifter.
//   req_valid/req_ready : per-requester handshake (NREQ bits each)
//   req_data/shamt/op   : packed per-requester operands (32/5/2 bits per requester)
//   rsp_valid/rsp_ready : one-entry registered response handshake
//   rsp_id/rsp_data     : owner index and shift result
// master = requesters + consumer, slave = shift_arbiter.
interface shift_arbiter_if #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*5-1:0] req_shamt;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       rsp_data;

  modport master (
    output req_valid, req_data, req_shamt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_lsl32.sv
// 32-bit left-only logarithmic barrel shifter, purely combinational.
//   target : value to shift
//   shamt  : shift amount 0..31
//   result : target << shamt, zero fill
module shift_lsl32
  import shift_pkg::*;
(
  input  logic [SH_W-1:0] target,
  input  logic [4:0]      shamt,
  output logic [SH_W-1:0] result
);

  logic [SH_W-1:0] stage [6];

  assign stage[0] = target;

  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? (stage[i] << (1 << i)) : stage[i];
  end

  assign result = stage[5];

endmodule

// File: rtl/shift_rr_arb.sv
// Round-robin arbiter: pointer register plus a fixed-priority search that
// starts at the pointer and wraps.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req       : per-requester request
//   advance   : the current grant was taken; pointer moves past the winner
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted requester
module shift_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (int'(grant_idx) == NREQ - 1) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one left barrel shifter between NREQ requesters. Right shifts are
// built by reversing the operand around the left shifter; SRA fill comes from
// a second shifter acting on an all-ones mask. One-entry registered response.
//   clk, rst : clock, synchronous active-high reset
//   bus      : shift_arbiter_if slave (request and response handshakes)
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no result held, rsp_valid=0
// ST_FULL  | result held in rsp_data/rsp_id, rsp_valid=1
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic            load;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            can_accept;
  logic            accept;

  logic [SH_W-1:0] op_data  [NREQ];
  logic [4:0]      op_shamt [NREQ];
  logic [1:0]      op_code  [NREQ];

  logic [SH_W-1:0] sel_x;
  logic [4:0]      sel_s;
  logic [1:0]      sel_op;
  logic            is_right;
  logic [SH_W-1:0] lsl_target;
  logic [SH_W-1:0] lsl_data;
  logic [SH_W-1:0] lsl_mask;
  logic [SH_W-1:0] shift_result;

  logic [SH_W-1:0] rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_data[i]  = bus.req_data[32*i +: 32];
    assign op_shamt[i] = bus.req_shamt[5*i +: 5];
    assign op_code[i]  = bus.req_op[2*i +: 2];
  end

  shift_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_accept    = (state_q == ST_EMPTY) || bus.rsp_ready;
  assign accept        = can_accept && (|grant);
  assign bus.req_ready = can_accept ? grant : '0;

  assign sel_x  = op_data[grant_idx];
  assign sel_s  = op_shamt[grant_idx];
  assign sel_op = op_code[grant_idx];

  assign is_right   = (sel_op == SHOP_SRL) || (sel_op == SHOP_SRA);
  assign lsl_target = is_right ? bit_rev32(sel_x) : sel_x;

  shift_lsl32 u_lsl_data (
    .target (lsl_target),
    .shamt  (sel_s),
    .result (lsl_data)
  );

  // Left-shifted all-ones, reversed and inverted, leaves the top s bits set.
  shift_lsl32 u_lsl_mask (
    .target ({SH_W{1'b1}}),
    .shamt  (sel_s),
    .result (lsl_mask)
  );

  always_comb begin
    shift_result = lsl_data;
    if (is_right) begin
      shift_result = bit_rev32(lsl_data);
      if ((sel_op == SHOP_SRA) && sel_x[SH_W-1]) begin
        shift_result = shift_result | ~bit_rev32(lsl_mask);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          load    = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept) begin
          load = 1'b1;
        end else if (bus.rsp_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rsp_data_q <= shift_result;
        rsp_id_q   <= grant_idx;
      end
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule
